// File: rtl/maze_tile_arbiter.sv
// -----------------------------------------------------------------------------
// maze_tile_arbiter
//
// Shares the single-port maze tile store between the five characters
// (0 pacman, 1 blinky, 2 pinky, 3 inky, 4 clyde). A granted requester gets
// the tile codes of the four neighbours of its current tile, packed as 4x2
// bits, together with a one-cycle done pulse.
//
// Transaction timeline (T = IDLE cycle in which the grant is taken):
//   T+1..T+4  READ  : one neighbour per cycle (up, left, down, right)
//   T+5       WAIT  : captures the last read's data
//   T+6       DONE  : done[g] pulses, tile_info[g] already holds the result
//
// Handshake: a requester raises req_valid[i] with req_tiles[i] and must hold
// both stable until it sees done[i]. Coordinates are sampled only at grant.
// req_valid[i] still high in the cycle after done[i] counts as a new request.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  [4:0]  per-requester request level
//   req_tiles  [69:0] requester i at [14i+13:14i] = {xtile[6:0], ytile[6:0]}
//   busy       [4:0]  one-hot, requester currently being served
//   done       [4:0]  one-cycle completion pulse per requester
//   tile_info  [39:0] requester i at [8i+7:8i], direction k at [2k+1:2k]
//   mem_rd            tile-store read strobe
//   mem_addr          tile address y*MAZE_W + x (0 when mem_rd is low)
//   mem_data   [1:0]  tile code, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module maze_tile_arbiter #(
   parameter int          MAZE_W   = 28,
   parameter int          MAZE_H   = 36,
   parameter int          ADDR_W   = 10,
   parameter logic [1:0]  OOB_TILE = 2'b01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        req_valid,
   input  logic [69:0]       req_tiles,
   output logic [4:0]        busy,
   output logic [4:0]        done,
   output logic [39:0]       tile_info,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [6:0]        W_LAST = 7'(MAZE_W - 1);
   localparam logic [6:0]        H_LAST = 7'(MAZE_H - 1);
   localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(MAZE_W);

   state_t           state_q, state_d;
   logic [1:0]       cnt_q;
   logic [2:0]       gnt_q;
   logic [2:0]       rr_ptr_q;
   logic [6:0]       x_q, y_q;
   logic             prev_oob_q;
   logic [2:0][1:0]  slot_q;
   logic [4:0][7:0]  tile_info_q;

   logic             sel_valid;
   logic [2:0]       sel_idx;
   logic [13:0]      sel_tiles;

   logic             centre_ok;
   logic             slot_oob;
   logic [6:0]       nx, ny;
   logic [ADDR_W-1:0] slot_addr;
   logic [1:0]       cap_data;
   logic [4:0]       gnt_onehot;

   // Reduce a value in 0..9 modulo 5.
   function automatic logic [2:0] wrap5(input logic [3:0] v);
      return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
   endfunction

   // Round-robin pick: first asserted requester at or after rr_ptr.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 3'd0;
      sel_tiles = 14'd0;
      for (int i = 0; i < 5; i++) begin
         if (!sel_valid && req_valid[wrap5({1'b0, rr_ptr_q} + 4'(i))]) begin
            sel_valid = 1'b1;
            sel_idx   = wrap5({1'b0, rr_ptr_q} + 4'(i));
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (sel_idx == 3'(i)) sel_tiles = req_tiles[14*i +: 14];
      end
   end

   // Neighbour coordinates for the slot selected by cnt_q. Left/right wrap
   // through the tunnel; up/down past the maze edge is an off-maze slot.
   always_comb begin
      centre_ok = (x_q <= W_LAST) && (y_q <= H_LAST);
      nx        = x_q;
      ny        = y_q;
      slot_oob  = 1'b0;
      case (cnt_q)
         2'd0: begin
            ny       = y_q - 7'd1;
            slot_oob = (y_q == 7'd0);
         end
         2'd1: nx = (x_q == 7'd0) ? W_LAST : x_q - 7'd1;
         2'd2: begin
            ny       = y_q + 7'd1;
            slot_oob = (y_q == H_LAST);
         end
         default: nx = (x_q == W_LAST) ? 7'd0 : x_q + 7'd1;
      endcase
      if (!centre_ok) slot_oob = 1'b1;
      slot_addr = ADDR_W'(ny) * W_ADDR + ADDR_W'(nx);
   end

   // Data for the slot read in the previous cycle.
   assign cap_data   = prev_oob_q ? OOB_TILE : mem_data;
   assign gnt_onehot = 5'b00001 << gnt_q;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state and outputs
   always_comb begin
      state_d  = state_q;
      busy     = 5'd0;
      done     = 5'd0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      case (state_q)
         IDLE: begin
            if (sel_valid) state_d = READ;
         end
         READ: begin
            busy     = gnt_onehot;
            mem_rd   = !slot_oob;
            mem_addr = slot_oob ? '0 : slot_addr;
            if (cnt_q == 2'd3) state_d = WAIT;
         end
         WAIT: begin
            busy    = gnt_onehot;
            state_d = DONE;
         end
         default: begin
            busy    = gnt_onehot;
            done    = gnt_onehot;
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: grant latch, read counter, capture slots, result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= 2'd0;
         gnt_q       <= 3'd0;
         rr_ptr_q    <= 3'd0;
         x_q         <= 7'd0;
         y_q         <= 7'd0;
         prev_oob_q  <= 1'b0;
         slot_q      <= '0;
         tile_info_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_valid) begin
                  gnt_q <= sel_idx;
                  x_q   <= sel_tiles[13:7];
                  y_q   <= sel_tiles[6:0];
                  cnt_q <= 2'd0;
               end
            end
            READ: begin
               cnt_q      <= cnt_q + 2'd1;
               prev_oob_q <= slot_oob;
               if (cnt_q != 2'd0) slot_q[cnt_q - 2'd1] <= cap_data;
            end
            WAIT: begin
               // Last slot goes straight into the result so tile_info is
               // already valid during the DONE cycle.
               for (int i = 0; i < 5; i++) begin
                  if (gnt_q == 3'(i))
                     tile_info_q[i] <= {cap_data, slot_q[2], slot_q[1], slot_q[0]};
               end
            end
            default: begin
               rr_ptr_q <= wrap5({1'b0, gnt_q} + 4'd1);
            end
         endcase
      end
   end

   assign tile_info = tile_info_q;

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maze_tile_arbiter
//
// Directed bench for maze_tile_arbiter. A behavioural tile store answers
// reads one cycle later and drives 2'b10 when no read was issued, so an
// off-maze slot that wrongly takes mem_data shows up as 10 instead of 01.
// Expected addresses and packed results are hand-computed in the vector
// table; the store holds addr % 4 except four overridden entries.
// -----------------------------------------------------------------------------
module tb_maze_tile_arbiter;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [4:0]        req_valid = 5'd0;
   logic [69:0]       req_tiles = 70'd0;
   logic [4:0]        busy;
   logic [4:0]        done;
   logic [39:0]       tile_info;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_data = 2'b00;

   maze_tile_arbiter #(
      .MAZE_W(28), .MAZE_H(36), .ADDR_W(ADDR_W), .OOB_TILE(2'b01)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_tiles(req_tiles),
      .busy(busy), .done(done), .tile_info(tile_info),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- tile store model ----------------
   logic [1:0] mem [0:1023];
   always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 2'b10;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [39:0] exp_ti = 40'd0;

   typedef struct packed {
      logic [2:0]       g;
      logic [6:0]       x;
      logic [6:0]       y;
      logic [3:0]       rd;     // bit k: read expected in slot k
      logic [3:0][9:0]  addr;   // expected mem_addr per slot (0 if no read)
      logic [7:0]       info;
   } vec_t;

   vec_t vecs [8];
   int   vec_of_req [5];
   int   sched [5];

   function automatic vec_t mk(input int g, input int x, input int y,
                               input logic [3:0] rd, input int a0,
                               input int a1, input int a2, input int a3,
                               input logic [7:0] info);
      vec_t v;
      v.g = 3'(g); v.x = 7'(x); v.y = 7'(y); v.rd = rd;
      v.addr[0] = 10'(a0); v.addr[1] = 10'(a1);
      v.addr[2] = 10'(a2); v.addr[3] = 10'(a3);
      v.info = info;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input vec_t v);
      req_tiles[14*v.g +: 14] = {v.x, v.y};
      req_valid[v.g]          = 1'b1;
   endtask

   // Single isolated transaction with cycle-exact checks T..T+7.
   task automatic run_vector(input vec_t v);
      logic [4:0] oh;
      oh = 5'b00001 << v.g;
      @(negedge clk);
      set_req(v);
      chk("idle_busy", busy, 5'd0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("busy", busy, oh);
         if (c <= 4) begin
            chk("mem_rd", mem_rd, v.rd[c-1]);
            chk("mem_addr", mem_addr, v.addr[c-1]);
            chk("done_early", done, 5'd0);
         end else if (c == 5) begin
            chk("wait_rd", mem_rd, 1'b0);
            chk("done_early", done, 5'd0);
            chk("info_hold", tile_info, exp_ti);
         end else begin
            exp_ti[8*v.g +: 8] = v.info;
            chk("done", done, oh);
            chk("tile_info", tile_info, exp_ti);
            req_valid[v.g] = 1'b0;
         end
      end
      @(negedge clk);
      chk("post_busy", busy, 5'd0);
      chk("post_done", done, 5'd0);
   endtask

   // Reset with the given requests already applied; returns at the negedge of
   // cycle T with rst just released.
   task automatic reset_with_requests(input logic [4:0] mask);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 5'd0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) req_tiles[14*i +: 14] =
         {vecs[vec_of_req[i]].x, vecs[vec_of_req[i]].y};
      req_valid = mask;
      @(negedge clk);
      exp_ti = 40'd0;
      chk("rst_busy", busy, 5'd0);
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_info", tile_info, exp_ti);
      rst = 1'b0;
   endtask

   // Back-to-back service of n transactions in the order held in sched[].
   task automatic check_schedule(input int n);
      for (int cyc = 1; cyc <= 7*n; cyc++) begin
         int j, ph;
         logic [4:0] oh;
         @(negedge clk);
         j  = (cyc - 1) / 7;
         ph = cyc - 7*j;
         oh = 5'b00001 << sched[j];
         if (ph == 6) exp_ti[8*sched[j] +: 8] = vecs[vec_of_req[sched[j]]].info;
         chk("sched_busy", busy, (ph <= 6) ? oh : 5'd0);
         chk("sched_done", done, (ph == 6) ? oh : 5'd0);
         chk("sched_info", tile_info, exp_ti);
         if (ph == 6 && j == n-1) req_valid = 5'd0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int a = 0; a < 1024; a++) mem[a] = 2'(a % 4);
      mem[125] = 2'd0; mem[152] = 2'd1; mem[181] = 2'd2; mem[154] = 2'd3;

      vecs[0] = mk(0, 13,  5, 4'b1111, 125,  152, 181, 154, 8'hE4);
      vecs[1] = mk(1,  0, 17, 4'b1111, 448,  503, 504, 477, 8'h4C);
      vecs[2] = mk(4, 27, 17, 4'b1111, 475,  502, 531, 476, 8'h3B);
      vecs[3] = mk(2,  5,  0, 4'b1110,   0,    4,  33,   6, 8'h91);
      vecs[4] = mk(3, 10, 35, 4'b1011, 962,  989,   0, 991, 8'hD6);
      vecs[5] = mk(0, 28,  3, 4'b0000,   0,    0,   0,   0, 8'h55);
      vecs[6] = mk(1,  3, 36, 4'b0000,   0,    0,   0,   0, 8'h55);
      vecs[7] = mk(2, 27, 35, 4'b1011, 979, 1006,   0, 980, 8'h1B);
      vec_of_req = '{0, 1, 3, 4, 2};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 5'd0);
      chk("reset_done", done, 5'd0);
      chk("reset_rd", mem_rd, 1'b0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_info", tile_info, 40'd0);
      rst = 1'b0;

      // Directed vectors
      for (int i = 0; i < 8; i++) run_vector(vecs[i]);

      // All five held from reset release: service 0,1,2,3,4
      reset_with_requests(5'b11111);
      sched = '{0, 1, 2, 3, 4};
      check_schedule(5);
      @(negedge clk);
      chk("contention_idle", busy, 5'd0);

      // Fairness between 0 and 2
      reset_with_requests(5'b00101);
      sched = '{0, 2, 0, 2, 0};
      check_schedule(4);
      @(negedge clk);
      chk("fair_idle", busy, 5'd0);

      // Reset in the middle of an inky transaction
      @(negedge clk);
      set_req(vecs[4]);                 // cycle T
      repeat (3) @(negedge clk);        // T+3
      chk("midop_busy", busy, 5'b01000);
      rst       = 1'b1;
      req_valid = 5'd0;
      @(negedge clk);                   // T+4
      exp_ti = 40'd0;
      chk("midop_rd", mem_rd, 1'b0);
      chk("midop_addr", mem_addr, 0);
      chk("midop_busy0", busy, 5'd0);
      chk("midop_done", done, 5'd0);
      chk("midop_info", tile_info, exp_ti);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("no_done3", done, 5'd0);
      end
      run_vector(vecs[4]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/maze_tile_arbiter.md
Name: maze_tile_arbiter

Overview:
- Shares the single-port maze tile store between the five characters: pacman, blinky, pinky, inky and clyde.
- Each character requests the tile types of the four neighbours around its current tile.
- The arbiter grants requesters round-robin and issues four sequential reads to the tile store.
- It returns the packed 4x2-bit neighbour info with a one-cycle done pulse. It sits between the character controllers (pacman, game_ghost) and the maze storage.

Parameters:
- MAZE_W, 28, maze width in tiles.
- MAZE_H, 36, maze height in tiles.
- ADDR_W, 10, tile-store address width; must satisfy MAZE_W*MAZE_H <= 2^ADDR_W.
- OOB_TILE, 2'b01, tile code substituted for an off-maze neighbour (wall).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  5  per-requester request level. Index 0 pacman, 1 blinky, 2 pinky, 3 inky, 4 clyde.
- req_tiles  in  70  requester i at [14i+13:14i], packed as {xtile[6:0], ytile[6:0]}.
- busy  out  5  one-hot; high for the requester currently being served.
- done  out  5  one-cycle pulse per requester at completion.
- tile_info  out  40  requester i at [8i+7:8i]; direction k at bits [2k+1:2k].
- mem_rd  out  1  tile-store read strobe.
- mem_addr  out  ADDR_W  tile address = y*MAZE_W + x.
- mem_data  in  2  tile code; valid the cycle after mem_rd.

Behaviour:
- Direction order: k=0 up (y-1), 1 left (x-1), 2 down (y+1), 3 right (x+1).
- States: IDLE, READ (4 cycles, counter 0..3), WAIT (1 cycle), DONE (1 cycle).
- IDLE, cycle T, with any req_valid high:
  - Selects the first asserted requester at or after rr_ptr, wrapping 4->0.
  - Latches that requester's coordinates and index g; goes to READ.
  - If no request is pending, stays in IDLE.
- READ, cycles T+1..T+4: for direction k=cnt, drives mem_addr and mem_rd=1.
- Data capture: mem_data is captured into slot k-1 on each cycle after a read. WAIT (T+5) exists to capture slot 3.
- DONE, T+6:
  - done[g]=1 and tile_info[g] holds the new value (registered at the T+6 edge).
  - rr_ptr <= g+1 mod 5; returns to IDLE at T+7.
- Latency and throughput: grant to done is 6 cycles; one transaction per 7 cycles; worst-case wait for any requester is 35 cycles.
- busy[g]=1 from T+1 through T+6; 0 otherwise.
- Requester handshake:
  - Must hold req_valid and req_tiles stable until its done pulse.
  - Coordinates are sampled only at grant.
  - req_valid still high in the cycle after done is a new request.
- tile_info[i] changes only in i's DONE cycle; other requesters' fields hold.
- Horizontal wrap (tunnel): x-1 at x=0 gives MAZE_W-1; x+1 at x=MAZE_W-1 gives 0. A memory read is still issued.
- Vertical off-maze: y-1 at y=0, or y+1 at y=MAZE_H-1:
  - mem_rd=0 in that slot; OOB_TILE is captured instead of mem_data.
  - Timing is unchanged.
- Invalid centre (x>=MAZE_W or y>=MAZE_H): all four slots are OOB_TILE with no reads; same timing.
- Address arithmetic is computed at full ADDR_W width; no truncation for legal coordinates.
- mem_addr is 0 whenever mem_rd=0.
- Requests arriving while not IDLE wait; they are not lost if held.
- Reset, including mid-transaction:
  - Next cycle: state IDLE, busy=0, done=0, mem_rd=0, mem_addr=0, tile_info=0, rr_ptr=0, capture slots=0.
  - An in-flight transaction is dropped with no done pulse.
  - req_valid is ignored while rst=1.

Test Plan:
- Single read: pacman req x=13, y=5 after reset.
  - mem_addr 125, 152, 181, 154 with mem_rd=1 at T+1..T+4.
  - mem_data returns 0, 1, 2, 3 → tile_info[7:0]=8'hE4, done[0] at T+6 only, busy[0] high T+1..T+6.
- Tunnel wrap:
  - Blinky at x=0, y=17: left address = 503.
  - Clyde at x=27, y=17: right address = 476.
  - All reads issued.
- Vertical edge: pinky at x=5, y=0.
  - mem_rd=0 at T+1; tile_info[17:16]=2'b01 regardless of mem_data.
  - Y=35 down slot is likewise OOB.
- All-five contention: req_valid=5'b11111 held from reset release.
  - Service order 0,1,2,3,4; done pulses at T+6, 13, 20, 27, 34.
  - Each requester's field is updated only at its own pulse.
- Round-robin fairness: req 0 and req 2 held continuously for 4 transactions.
  - Grant order 0,2,0,2; neither is served twice consecutively.
- Reset mid-op: rst=1 at T+3 of an inky transaction.
  - Next cycle mem_rd=0, busy=0, tile_info=0; no done[3].
  - A re-request after reset completes in 6 cycles with correct data.
